// File: rtl/ram32x4_access_ctrl.sv
// ram32x4_access_ctrl
//
// Sequences every access to the 32x4 synchronous RAM. Two requesters share
// the single RAM port:
//   * a user write requester (level request, held until acknowledged)
//   * a periodic read scanner that walks addresses 0..2**ADDR_W-1 and hands
//     each word, tagged with its address, to the HEX display path.
// Writes win arbitration in IDLE, but a read that has started always runs to
// completion before a write is considered.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   wr_req              level write request, held until wr_ack
//   wr_addr, wr_data    write address/data, sampled when the request is accepted
//   wr_ack              1-cycle pulse, coincides with the RAM write cycle
//   scan_tick           1-cycle pulse, asks for the next scan read
//   ram_addr            RAM address (registered, holds last value)
//   ram_wdata           RAM write data (registered, holds last value)
//   ram_wren            RAM write enable (registered, high only in WRITE)
//   ram_q               RAM read data, valid RD_LAT cycles after the address edge
//   rd_valid            1-cycle pulse, rd_addr/rd_data hold a completed read
//   rd_addr, rd_data    address and data of the returned read
//   busy                high whenever the sequencer is not in IDLE
//
// Timing of a scan read (RD_LAT = 1):
//   edge E0 : IDLE sees scan_pend, ram_addr <= scan_addr, enter READ
//   edge E1 : RAM samples ram_addr, enter WAIT
//   edge E2 : ram_q valid, capture rd_data/rd_addr, rd_valid high after E2
// so rd_valid rises 1+RD_LAT cycles after READ entry.

module ram32x4_access_ctrl #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 4,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    input  logic              scan_tick,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q,
    output logic              rd_valid,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_READ  = 2'd2;
    localparam logic [1:0] S_WAIT  = 2'd3;

    // WAIT lasts RD_LAT cycles; the counter runs 0..RD_LAT-1 and the read
    // data is captured on the edge that ends the last WAIT cycle.
    localparam logic [1:0] WAIT_LAST = 2'(RD_LAT - 1);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [1:0]        state_q,     state_d;
    logic [ADDR_W-1:0] scan_addr_q, scan_addr_d;
    logic              scan_pend_q, scan_pend_d;
    logic              wr_armed_q,  wr_armed_d;
    logic [1:0]        wait_cnt_q,  wait_cnt_d;

    logic [ADDR_W-1:0] ram_addr_q,  ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic              ram_wren_q,  ram_wren_d;
    logic              wr_ack_q,    wr_ack_d;

    logic              rd_valid_q,  rd_valid_d;
    logic [ADDR_W-1:0] rd_addr_q,   rd_addr_d;
    logic [DATA_W-1:0] rd_data_q,   rd_data_d;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        scan_addr_d = scan_addr_q;
        wait_cnt_d  = wait_cnt_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        rd_addr_d   = rd_addr_q;
        rd_data_d   = rd_data_q;

        // Strobes default low: each is a single-cycle pulse.
        ram_wren_d  = 1'b0;
        wr_ack_d    = 1'b0;
        rd_valid_d  = 1'b0;

        // Ticks merge into one pending flag in every state. Clearing happens
        // only at read completion, where a coincident tick re-sets it below.
        scan_pend_d = scan_pend_q | scan_tick;

        // Re-arm once the requester has been seen to drop its request, so a
        // held wr_req produces exactly one RAM write.
        wr_armed_d  = wr_armed_q | ~wr_req;

        case (state_q)
            S_IDLE: begin
                if (wr_req && wr_armed_q) begin
                    // Write has priority over a pending scan read. The RAM
                    // strobes are registered here so they are visible for
                    // exactly the one WRITE cycle.
                    state_d     = S_WRITE;
                    ram_addr_d  = wr_addr;
                    ram_wdata_d = wr_data;
                    ram_wren_d  = 1'b1;
                    wr_ack_d    = 1'b1;
                    wr_armed_d  = 1'b0;
                end else if (scan_pend_q) begin
                    state_d    = S_READ;
                    ram_addr_d = scan_addr_q;
                end
            end

            S_WRITE: begin
                state_d = S_IDLE;
            end

            S_READ: begin
                // The RAM samples ram_addr on the edge leaving READ.
                state_d    = S_WAIT;
                wait_cnt_d = 2'd0;
            end

            S_WAIT: begin
                if (wait_cnt_q == WAIT_LAST) begin
                    state_d     = S_IDLE;
                    rd_valid_d  = 1'b1;
                    rd_data_d   = ram_q;
                    rd_addr_d   = scan_addr_q;
                    // Natural wrap at 2**ADDR_W.
                    scan_addr_d = scan_addr_q + 1'b1;
                    // A tick on the completing edge keeps the flag set.
                    scan_pend_d = scan_tick;
                end else begin
                    wait_cnt_d = wait_cnt_q + 2'd1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers. Reset abandons any operation in flight, so an
    // interrupted read never produces rd_valid.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            scan_addr_q <= '0;
            scan_pend_q <= 1'b0;
            wr_armed_q  <= 1'b1;
            wait_cnt_q  <= 2'd0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_wren_q  <= 1'b0;
            wr_ack_q    <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_addr_q   <= '0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            scan_addr_q <= scan_addr_d;
            scan_pend_q <= scan_pend_d;
            wr_armed_q  <= wr_armed_d;
            wait_cnt_q  <= wait_cnt_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_wren_q  <= ram_wren_d;
            wr_ack_q    <= wr_ack_d;
            rd_valid_q  <= rd_valid_d;
            rd_addr_q   <= rd_addr_d;
            rd_data_q   <= rd_data_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign ram_wren  = ram_wren_q;
    assign wr_ack    = wr_ack_q;
    assign rd_valid  = rd_valid_q;
    assign rd_addr   = rd_addr_q;
    assign rd_data   = rd_data_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_ram32x4_access_ctrl.sv
// Testbench for ram32x4_access_ctrl: a synchronous RAM model with RD_LAT
// output stages, a transaction-level scoreboard (shadow memory plus the next
// expected scan address) checked on every falling edge, and directed
// scenarios with hand-computed expectations.

module tb_ram32x4_access_ctrl;

    localparam int AW = 5;
    localparam int DW = 4;
    localparam int RL = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          preload = 1'b1;
    logic          wr_req = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          scan_tick = 1'b0;
    logic          wr_ack, ram_wren, rd_valid, busy;
    logic [AW-1:0] ram_addr, rd_addr;
    logic [DW-1:0] ram_wdata, ram_q, rd_data;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ram32x4_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL)) dut (
        .clk(clk), .rst(rst),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .scan_tick(scan_tick),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wren(ram_wren), .ram_q(ram_q),
        .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy)
    );

    // Preload pattern for RAM and shadow memory.
    function automatic logic [DW-1:0] pat(int i);
        return DW'((i * 7 + 3) % 16);
    endfunction

    // Synchronous RAM: address sampled on an edge, q valid RL edges later.
    logic [DW-1:0] mem   [32];
    logic [DW-1:0] qpipe [RL];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 32; i++) mem[i] <= pat(i);
        end else if (ram_wren) begin
            mem[ram_addr] <= ram_wdata;
        end
        qpipe[0] <= mem[ram_addr];
        for (int k = 1; k < RL; k++) qpipe[k] <= qpipe[k-1];
    end
    assign ram_q = qpipe[RL-1];

    task automatic chk(string nm, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard: every acknowledged write lands in the shadow memory with the
    // data the bench requested; reads come back in scan order with shadow data.
    logic [DW-1:0] shadow [32];
    int exp_scan = 0;
    int rd_cnt   = 0;
    int ack_cnt  = 0;
    always @(negedge clk) begin
        if (preload) begin
            for (int i = 0; i < 32; i++) shadow[i] = pat(i);
        end else begin
            chk("wren_vs_ack", int'(ram_wren), int'(wr_ack));
            if (wr_ack) begin
                chk("sb_wr_addr", int'(ram_addr), int'(wr_addr));
                chk("sb_wr_data", int'(ram_wdata), int'(wr_data));
                shadow[wr_addr] = wr_data;
                ack_cnt++;
            end
            if (rd_valid) begin
                chk("sb_rd_addr", int'(rd_addr), exp_scan);
                chk("sb_rd_data", int'(rd_data), int'(shadow[exp_scan]));
                exp_scan = (exp_scan + 1) % 32;
                rd_cnt++;
            end
            if (rst) exp_scan = 0;
        end
    end

    task automatic step(int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One scan tick, then wait (bounded) for rd_valid; lat = edges after the
    // tick-sampling edge until rd_valid is visible.
    task automatic do_read(output int lat);
        scan_tick = 1'b1;
        step();
        scan_tick = 1'b0;
        lat = 0;
        while (!rd_valid && lat < 20) begin
            step();
            lat++;
        end
    endtask

    int lat, a0, r0;

    initial begin
        // 1: reset
        step(2);
        rst = 1'b0;
        preload = 1'b0;
        chk("rst_busy", int'(busy), 0);
        chk("rst_wr_ack", int'(wr_ack), 0);
        chk("rst_wren", int'(ram_wren), 0);
        chk("rst_ram_addr", int'(ram_addr), 0);
        chk("rst_ram_wdata", int'(ram_wdata), 0);
        chk("rst_rd_valid", int'(rd_valid), 0);
        chk("rst_rd_addr", int'(rd_addr), 0);
        chk("rst_rd_data", int'(rd_data), 0);

        // 2: held write request gives one write
        a0 = ack_cnt;
        wr_addr = 5'd5; wr_data = 4'hA; wr_req = 1'b1;
        step();
        chk("t2_ack", int'(wr_ack), 1);
        chk("t2_wren", int'(ram_wren), 1);
        chk("t2_addr", int'(ram_addr), 5);
        chk("t2_wdata", int'(ram_wdata), 10);
        chk("t2_busy", int'(busy), 1);
        step(3);
        chk("t2_one_ack", ack_cnt - a0, 1);
        chk("t2_wren_low", int'(ram_wren), 0);
        chk("t2_addr_hold", int'(ram_addr), 5);
        wr_req = 1'b0;
        step(2);
        chk("t2_no_rewrite", ack_cnt - a0, 1);
        wr_addr = 5'd6; wr_data = 4'h3; wr_req = 1'b1;
        step();
        chk("t2_rearm_ack", int'(wr_ack), 1);
        wr_req = 1'b0;
        step();
        chk("t2_two_acks", ack_cnt - a0, 2);

        // 3: 33 scan reads, 8 cycles apart
        for (int i = 0; i < 33; i++) begin
            do_read(lat);
            chk("t3_latency", lat, 2 + RL);
            chk("t3_rd_addr", int'(rd_addr), i % 32);
            if (i == 0)  chk("t3_data0", int'(rd_data), 3);
            if (i == 5)  chk("t3_data5", int'(rd_data), 10);
            if (i == 6)  chk("t3_data6", int'(rd_data), 3);
            if (i == 31) chk("t3_data31", int'(rd_data), 12);
            if (lat < 7) step(7 - lat);
        end

        // 4: write and tick on the same edge -> write first, then read addr 1
        wr_addr = 5'd9; wr_data = 4'hC; wr_req = 1'b1; scan_tick = 1'b1;
        step();
        scan_tick = 1'b0;
        chk("t4_ack", int'(wr_ack), 1);
        chk("t4_wren", int'(ram_wren), 1);
        step();
        chk("t4_idle_busy", int'(busy), 0);
        chk("t4_idle_ack", int'(wr_ack), 0);
        step();
        chk("t4_read_busy", int'(busy), 1);
        chk("t4_read_wren", int'(ram_wren), 0);
        chk("t4_read_addr", int'(ram_addr), 1);
        wr_req = 1'b0;
        step(2);
        chk("t4_rd_valid", int'(rd_valid), 1);
        chk("t4_rd_addr", int'(rd_addr), 1);
        chk("t4_rd_data", int'(rd_data), 10);
        step(3);

        // 5: write to the address being read, requested during WAIT
        scan_tick = 1'b1;
        step();
        scan_tick = 1'b0;
        step(2);
        wr_addr = 5'd2; wr_data = 4'h5; wr_req = 1'b1;
        step();
        chk("t5_rd_valid", int'(rd_valid), 1);
        chk("t5_old_data", int'(rd_data), 1);
        chk("t5_no_ack_yet", int'(wr_ack), 0);
        step();
        chk("t5_ack", int'(wr_ack), 1);
        chk("t5_ram_addr", int'(ram_addr), 2);
        chk("t5_ram_wdata", int'(ram_wdata), 5);
        wr_req = 1'b0;
        step(3);
        for (int i = 0; i < 32; i++) begin
            do_read(lat);
            step(3);
        end
        chk("t5_wrap_addr", int'(rd_addr), 2);
        chk("t5_new_data", int'(rd_data), 5);

        // 6: reset during WAIT aborts the read and restarts the scan
        scan_tick = 1'b1;
        step();
        scan_tick = 1'b0;
        step(2);
        r0 = rd_cnt;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_busy", int'(busy), 0);
        chk("t6_rd_valid", int'(rd_valid), 0);
        step(5);
        chk("t6_no_valid", rd_cnt - r0, 0);
        do_read(lat);
        chk("t6_restart_addr", int'(rd_addr), 0);
        chk("t6_restart_data", int'(rd_data), 3);
        step(3);

        // ticks on three consecutive edges merge into one read
        r0 = rd_cnt;
        scan_tick = 1'b1;
        step(3);
        scan_tick = 1'b0;
        step(10);
        chk("t6_merge", rd_cnt - r0, 1);

        // tick on the completing edge is kept -> a second read
        r0 = rd_cnt;
        scan_tick = 1'b1;
        step();
        scan_tick = 1'b0;
        step(2);
        scan_tick = 1'b1;
        step();
        scan_tick = 1'b0;
        step(10);
        chk("t6_set_wins", rd_cnt - r0, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
